// File: rtl/addr_range_scanner.sv
// Address-range scanner: walks memory from lo to hi over a 1-cycle-latency
// read port, stops at the first word equal to the latched key, and reports
// found / found_adr together with a one-cycle done strobe.
module addr_range_scanner #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          abort,
  input  logic [AW-1:0] start_adr,
  input  logic [AW-1:0] end_adr,
  input  logic          same,
  input  logic [DW-1:0] key,
  output logic          rd_en,
  output logic [AW-1:0] rd_adr,
  input  logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [AW-1:0] found_adr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [AW-1:0] cur;
  logic [AW-1:0] lim;
  logic [DW-1:0] key_q;
  logic          swap;
  logic [AW-1:0] lo;
  logic [AW-1:0] hi;
  logic          hit;

  // The address compare is authoritative; `same` is only honoured when the
  // addresses actually agree, where it cannot change the ordering result.
  assign swap = (start_adr > end_adr) && !(same && (start_adr == end_adr));
  assign lo   = swap ? end_adr   : start_adr;
  assign hi   = swap ? start_adr : end_adr;
  assign hit  = (rd_data == key_q);

  // The read address always follows the scan pointer.
  assign rd_adr = cur;

  // Next-state decode; abort outranks go, match and end-of-range.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (go && !abort) nxt = READ;
      READ:    nxt = abort ? IDLE : CHECK;
      CHECK: begin
        if (abort)                   nxt = IDLE;
        else if (hit || (cur == lim)) nxt = DONE;
        else                         nxt = READ;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, scan registers and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur       <= '0;
      lim       <= '0;
      key_q     <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      found_adr <= '0;
    end else begin
      state <= nxt;
      rd_en <= (nxt == READ);
      busy  <= (nxt != IDLE);
      done  <= (nxt == DONE);
      unique case (state)
        IDLE: begin
          if (go && !abort) begin
            cur       <= lo;
            lim       <= hi;
            key_q     <= key;
            found     <= 1'b0;
            found_adr <= '0;
          end
        end
        READ: begin
          if (abort) found <= 1'b0;
        end
        CHECK: begin
          if (abort) begin
            found <= 1'b0;
          end else if (hit) begin
            found     <= 1'b1;
            found_adr <= cur;
          end else if (cur != lim) begin
            cur <= cur + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_range_scanner.sv
// Self-checking bench for addr_range_scanner: directed scenarios plus random
// scans, each compared with a behavioural scan model over a memory array.
module tb_addr_range_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] start_adr = '0;
  logic [4:0] end_adr = '0;
  logic       same = 1'b0;
  logic [7:0] key = '0;
  logic       rd_en;
  logic [4:0] rd_adr;
  logic [7:0] rd_data = '0;
  logic       busy;
  logic       done;
  logic       found;
  logic [4:0] found_adr;

  logic [7:0] mem [0:31];
  int checks = 0;
  int errors = 0;

  addr_range_scanner #(.AW(5), .DW(8)) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort),
    .start_adr(start_adr), .end_adr(end_adr), .same(same), .key(key),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data),
    .busy(busy), .done(done), .found(found), .found_adr(found_adr)
  );

  always #5 clk = ~clk;

  // Memory with one cycle of read latency.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_adr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete scan, compared against the model: the scan visits lo..hi
  // in order and stops at the first word equal to the key.
  task automatic run_scan(input string nm, input logic [4:0] s, input logic [4:0] e,
                          input logic sm, input logic [7:0] k);
    int lo, hi, kk, exp_done, exp_adr, got_done;
    logic exp_found;
    int q[$];
    lo = (s < e) ? int'(s) : int'(e);
    hi = (s < e) ? int'(e) : int'(s);
    kk = hi - lo + 1;
    exp_found = 1'b0;
    exp_adr = 0;
    for (int a = lo; a <= hi; a++) begin
      if (mem[a] == k) begin
        exp_found = 1'b1;
        exp_adr = a;
        kk = a - lo + 1;
        break;
      end
    end
    exp_done = 2 * kk + 1;

    @(negedge clk);
    start_adr = s; end_adr = e; same = sm; key = k; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    start_adr = 5'($urandom); end_adr = 5'($urandom); key = 8'($urandom);
    got_done = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (rd_en) q.push_back(int'(rd_adr));
      if (done) begin
        got_done = c;
        break;
      end
    end
    chk({nm, ".done_cycle"}, got_done, exp_done);
    chk({nm, ".found"}, found, exp_found);
    chk({nm, ".found_adr"}, found_adr, exp_adr);
    chk({nm, ".nreads"}, q.size(), kk);
    for (int i = 0; i < q.size() && i < kk; i++)
      chk({nm, ".rd_adr"}, q[i], lo + i);
    @(negedge clk);
    chk({nm, ".done_one_cycle"}, done, 1'b0);
    chk({nm, ".idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int seen_done;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    // Power-on reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rd_en", rd_en, 1'b0);
    chk("reset.rd_adr", rd_adr, 0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.found", found, 1'b0);
    chk("reset.found_adr", found_adr, 0);
    @(negedge clk) reset = 1'b1;

    // Reset asserted during CHECK clears outputs at once.
    @(negedge clk);
    start_adr = 5'd0; end_adr = 5'd20; same = 1'b0; key = 8'h77; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    @(negedge clk);
    chk("midrst.read_cycle", rd_en, 1'b1);
    @(negedge clk);
    chk("midrst.busy_before", busy, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.rd_en", rd_en, 1'b0);
    chk("midrst.rd_adr", rd_adr, 0);
    chk("midrst.done", done, 1'b0);
    chk("midrst.found", found, 1'b0);
    chk("midrst.found_adr", found_adr, 0);
    @(negedge clk) reset = 1'b1;
    mem[2] = 8'h11;
    run_scan("single", 5'd2, 5'd2, 1'b1, 8'h11);

    // First match in the middle of the range.
    for (int i = 3; i <= 9; i++) mem[i] = 8'h00;
    mem[6] = 8'hA5;
    run_scan("midmatch", 5'd3, 5'd9, 1'b0, 8'hA5);

    // Full range with no match: 32 reads, no wrap past 31.
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 254));
    run_scan("fullrange", 5'd0, 5'd31, 1'b0, 8'hFF);
    chk("fullrange.rd_adr_end", rd_adr, 31);

    // Reversed bounds scan from the lower address.
    mem[4] = 8'h3C;
    run_scan("reversed", 5'd12, 5'd4, 1'b0, 8'h3C);

    // Abort mid-scan with an ignored go re-pulse.
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    @(negedge clk);
    start_adr = 5'd0; end_adr = 5'd20; same = 1'b0; key = 8'h5A; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    seen_done = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) seen_done++;
      if (c == 1) chk("abort.found_cleared", found, 1'b0);
      if (c == 4) begin go = 1'b1; start_adr = 5'd3; end_adr = 5'd3; end
      if (c == 5) begin
        go = 1'b0;
        chk("abort.go_ignored_adr", rd_adr, 2);
        chk("abort.go_ignored_rd", rd_en, 1'b1);
      end
      if (c == 6) begin
        chk("abort.busy_before", busy, 1'b1);
        abort = 1'b1;
      end
      if (c == 7) begin
        abort = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.rd_en", rd_en, 1'b0);
        chk("abort.found", found, 1'b0);
      end
      if (c == 14) chk("abort.stays_idle", busy, 1'b0);
    end
    chk("abort.no_done", seen_done, 0);

    // go and abort together in IDLE: no scan starts.
    @(negedge clk);
    start_adr = 5'd7; end_adr = 5'd9; key = 8'h42; go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    chk("goabort.busy", busy, 1'b0);
    chk("goabort.rd_en", rd_en, 1'b0);
    chk("goabort.done", done, 1'b0);
    run_scan("after_goabort", 5'd7, 5'd9, 1'b0, 8'h42);

    // Random scans, including disagreeing `same` indications.
    for (int t = 0; t < 20; t++) begin
      logic [4:0] s, e;
      logic sm;
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 15));
      s = 5'($urandom);
      e = 5'($urandom);
      sm = ($urandom_range(0, 3) == 0) ? (s != e) : (s == e);
      run_scan("random", s, e, sm, 8'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
